// File: rtl/video_timing_gen.sv
// Raster timing generator: signed pixel/line coordinates with blanking at negative positions,
// plus sync, data-enable, line/frame strobes and a frame counter, all registered and aligned.
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               ce,
   output logic signed [11:0] hpos,
   output logic signed [11:0] vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               fsync,
   output logic               line_start,
   output logic               vblank,
   output logic [15:0]        frame_count
);

   localparam int H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int V_BLANK = V_FP + V_SYNC + V_BP;

   localparam logic signed [11:0] H_FIRST = 12'(-H_BLANK);
   localparam logic signed [11:0] H_LAST  = 12'(H_ACTIVE - 1);
   localparam logic signed [11:0] HS_BEG  = 12'(H_FP - H_BLANK);
   localparam logic signed [11:0] HS_END  = 12'(H_FP + H_SYNC - 1 - H_BLANK);
   localparam logic signed [11:0] V_FIRST = 12'(-V_BLANK);
   localparam logic signed [11:0] V_LAST  = 12'(V_ACTIVE - 1);
   localparam logic signed [11:0] VS_BEG  = 12'(V_FP - V_BLANK);
   localparam logic signed [11:0] VS_END  = 12'(V_FP + V_SYNC - 1 - V_BLANK);

   generate
      if ((H_ACTIVE + H_BLANK) > 2047 || (V_ACTIVE + V_BLANK) > 2047) begin : g_cfg_err
         $error("video_timing_gen: raster totals exceed 12-bit signed range");
      end
   endgenerate

   logic signed [11:0] hpos_q, vpos_q;
   logic signed [11:0] h_d, v_d;
   logic               hsync_q, vsync_q, de_q, fsync_q, line_start_q, vblank_q;
   logic [15:0]        frame_count_q;
   logic               frame_start_d;

   // Position of the pixel the next enabled edge moves to; all outputs are decoded from it
   // so they line up with the registered coordinates.
   always_comb begin
      h_d = hpos_q + 12'sd1;
      v_d = vpos_q;
      if (hpos_q == H_LAST) begin
         h_d = H_FIRST;
         v_d = (vpos_q == V_LAST) ? V_FIRST : vpos_q + 12'sd1;
      end
      frame_start_d = (h_d == H_FIRST) && (v_d == V_FIRST);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         hpos_q        <= H_LAST;
         vpos_q        <= V_LAST;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         de_q          <= 1'b0;
         fsync_q       <= 1'b0;
         line_start_q  <= 1'b0;
         vblank_q      <= 1'b0;
         frame_count_q <= 16'd0;
      end else if (ce) begin
         hpos_q        <= h_d;
         vpos_q        <= v_d;
         hsync_q       <= (h_d >= HS_BEG && h_d <= HS_END) ? H_POL : ~H_POL;
         vsync_q       <= (v_d >= VS_BEG && v_d <= VS_END) ? V_POL : ~V_POL;
         de_q          <= ~h_d[11] & ~v_d[11];
         vblank_q      <= v_d[11];
         line_start_q  <= (h_d == H_FIRST);
         fsync_q       <= frame_start_d;
         if (frame_start_d) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end else begin
         // Strobes are single-cycle even when the pixel is held.
         fsync_q      <= 1'b0;
         line_start_q <= 1'b0;
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign fsync       = fsync_q;
   assign line_start  = line_start_q;
   assign vblank      = vblank_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 1650x750 raster, a tiny 7x5 raster with
// active-low syncs, and a 1x1 raster that wraps the frame counter.
module tb_video_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Default timing
   logic               rst_a = 1'b1, ce_a = 1'b0;
   logic signed [11:0] hpos_a, vpos_a;
   logic               hsync_a, vsync_a, de_a, fsync_a, ls_a, vblank_a;
   logic [15:0]        fc_a;

   video_timing_gen dut_a (
      .pixel_clk(clk), .rst(rst_a), .ce(ce_a),
      .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
      .de(de_a), .fsync(fsync_a), .line_start(ls_a), .vblank(vblank_a),
      .frame_count(fc_a)
   );

   // Small raster: H total 7 (blank 3), V total 5 (blank 3), active-low syncs
   logic               rst_b = 1'b1, ce_b = 1'b0;
   logic signed [11:0] hpos_b, vpos_b;
   logic               hsync_b, vsync_b, de_b, fsync_b, ls_b, vblank_b;
   logic [15:0]        fc_b;

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0)
   ) dut_b (
      .pixel_clk(clk), .rst(rst_b), .ce(ce_b),
      .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
      .de(de_b), .fsync(fsync_b), .line_start(ls_b), .vblank(vblank_b),
      .frame_count(fc_b)
   );

   // 1x1 raster with no blanking: a new frame every enabled cycle
   logic               rst_c = 1'b1, ce_c = 1'b1;
   logic signed [11:0] hpos_c, vpos_c;
   logic               hsync_c, vsync_c, de_c, fsync_c, ls_c, vblank_c;
   logic [15:0]        fc_c;
   logic               wrap_done = 1'b0;

   video_timing_gen #(
      .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
      .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
   ) dut_c (
      .pixel_clk(clk), .rst(rst_c), .ce(ce_c),
      .hpos(hpos_c), .vpos(vpos_c), .hsync(hsync_c), .vsync(vsync_c),
      .de(de_c), .fsync(fsync_c), .line_start(ls_c), .vblank(vblank_c),
      .frame_count(fc_c)
   );

   initial begin : wrap_test
      tick();
      tick();
      rst_c = 1'b0;
      tick();
      check("c_fc_first", int'(fc_c), 1);
      repeat (65534) tick();
      check("c_fc_ffff", int'(fc_c), 65535);
      tick();
      check("c_fc_wrap", int'(fc_c), 0);
      check("c_fsync_wrap", int'(fsync_c), 1);
      check("c_ls_wrap", int'(ls_c), 1);
      check("c_hpos", int'(hpos_c), 0);
      check("c_vpos", int'(vpos_c), 0);
      check("c_de", int'(de_c), 1);
      check("c_vblank", int'(vblank_c), 0);
      check("c_hsync", int'(hsync_c), 0);
      check("c_vsync", int'(vsync_c), 0);
      $display("wrap: frame_count=%0d fsync=%0d", fc_c, fsync_c);
      wrap_done = 1'b1;
   end

   initial begin : main_test
      int exp_h[8];
      int line, col;
      int first_hs, hs_cnt, second_ls, ls_cnt, vs_cnt, first_vs;
      int vb_cnt, de_cnt, first_de, h_at_de, v_at_de, fs_cnt;

      exp_h = '{-3, -2, -1, 0, 1, 2, 3, -3};

      // ---------------- small raster ----------------
      ce_b = 1'b1;
      tick();
      tick();
      check("b_rst_hpos", int'(hpos_b), 3);
      check("b_rst_vpos", int'(vpos_b), 1);
      check("b_rst_hsync", int'(hsync_b), 1);
      check("b_rst_vsync", int'(vsync_b), 1);
      check("b_rst_fc", int'(fc_b), 0);
      rst_b = 1'b0;
      for (int k = 0; k < 35; k++) begin
         tick();
         line = k / 7;
         col  = k % 7;
         if (k < 8) check($sformatf("b_hseq[%0d]", k), int'(hpos_b), exp_h[k]);
         check($sformatf("b_hpos[%0d]", k), int'(hpos_b), col - 3);
         check($sformatf("b_vpos[%0d]", k), int'(vpos_b), line - 3);
         check($sformatf("b_hsync[%0d]", k), int'(hsync_b), (col != 1) ? 1 : 0);
         check($sformatf("b_vsync[%0d]", k), int'(vsync_b), (line != 1) ? 1 : 0);
         check($sformatf("b_de[%0d]", k), int'(de_b), (col >= 3 && line >= 3) ? 1 : 0);
         check($sformatf("b_fsync[%0d]", k), int'(fsync_b), (k == 0) ? 1 : 0);
         check($sformatf("b_ls[%0d]", k), int'(ls_b), (col == 0) ? 1 : 0);
         check($sformatf("b_vblank[%0d]", k), int'(vblank_b), (line < 3) ? 1 : 0);
         check($sformatf("b_fc[%0d]", k), int'(fc_b), 1);
         $display("b k=%0d hpos=%0d vpos=%0d hs=%0d vs=%0d de=%0d", k, hpos_b, vpos_b, hsync_b, vsync_b, de_b);
      end
      tick();
      check("b_frame2_fsync", int'(fsync_b), 1);
      check("b_frame2_fc", int'(fc_b), 2);
      check("b_frame2_hpos", int'(hpos_b), -3);
      check("b_frame2_vpos", int'(vpos_b), -3);

      // ce 1,0,0,1 across a line boundary starting from hpos=3
      repeat (6) tick();
      check("b_pre_hpos", int'(hpos_b), 3);
      tick();
      check("b_ce1_hpos", int'(hpos_b), -3);
      check("b_ce1_vpos", int'(vpos_b), -2);
      check("b_ce1_ls", int'(ls_b), 1);
      check("b_ce1_vsync", int'(vsync_b), 0);
      ce_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("b_ce0_hpos[%0d]", k), int'(hpos_b), -3);
         check($sformatf("b_ce0_vpos[%0d]", k), int'(vpos_b), -2);
         check($sformatf("b_ce0_ls[%0d]", k), int'(ls_b), 0);
         check($sformatf("b_ce0_vsync[%0d]", k), int'(vsync_b), 0);
      end
      ce_b = 1'b1;
      tick();
      check("b_ce_back_hpos", int'(hpos_b), -2);
      check("b_ce_back_ls", int'(ls_b), 0);
      check("b_ce_back_hsync", int'(hsync_b), 0);

      // Reset mid-frame from an active pixel
      repeat (17) tick();
      check("b_mid_hpos", int'(hpos_b), 1);
      check("b_mid_vpos", int'(vpos_b), 0);
      check("b_mid_de", int'(de_b), 1);
      rst_b = 1'b1;
      tick();
      check("b_mrst_hpos", int'(hpos_b), 3);
      check("b_mrst_vpos", int'(vpos_b), 1);
      check("b_mrst_de", int'(de_b), 0);
      check("b_mrst_hsync", int'(hsync_b), 1);
      check("b_mrst_vsync", int'(vsync_b), 1);
      check("b_mrst_fc", int'(fc_b), 0);
      check("b_mrst_vblank", int'(vblank_b), 0);
      check("b_mrst_fsync", int'(fsync_b), 0);
      check("b_mrst_ls", int'(ls_b), 0);
      rst_b = 1'b0;
      tick();
      check("b_rel_fsync", int'(fsync_b), 1);
      check("b_rel_fc", int'(fc_b), 1);
      check("b_rel_hpos", int'(hpos_b), -3);
      check("b_rel_vpos", int'(vpos_b), -3);

      // ---------------- default raster ----------------
      ce_a = 1'b1;
      tick();
      tick();
      check("a_rst_hpos", int'(hpos_a), 1279);
      check("a_rst_vpos", int'(vpos_a), 719);
      check("a_rst_de", int'(de_a), 0);
      check("a_rst_fsync", int'(fsync_a), 0);
      check("a_rst_ls", int'(ls_a), 0);
      check("a_rst_vblank", int'(vblank_a), 0);
      check("a_rst_fc", int'(fc_a), 0);
      check("a_rst_hsync", int'(hsync_a), 0);
      check("a_rst_vsync", int'(vsync_a), 0);
      rst_a = 1'b0;
      tick();
      check("a_first_hpos", int'(hpos_a), -370);
      check("a_first_vpos", int'(vpos_a), -30);
      check("a_first_fsync", int'(fsync_a), 1);
      check("a_first_ls", int'(ls_a), 1);
      check("a_first_vblank", int'(vblank_a), 1);
      check("a_first_fc", int'(fc_a), 1);

      first_hs = -1; hs_cnt = 0; second_ls = -1; ls_cnt = 0; vs_cnt = 0; first_vs = -1;
      vb_cnt = 0; de_cnt = 0; first_de = -1; h_at_de = 9999; v_at_de = 9999; fs_cnt = 0;
      for (int i = 0; i < 31 * 1650; i++) begin
         if (i > 0) tick();
         if (hsync_a) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = i;
         end
         if (ls_a) begin
            ls_cnt++;
            if (i > 0 && second_ls < 0) second_ls = i;
         end
         if (vsync_a) begin
            vs_cnt++;
            if (first_vs < 0) first_vs = i;
         end
         if (vblank_a) vb_cnt++;
         if (fsync_a) fs_cnt++;
         if (de_a) begin
            de_cnt++;
            if (first_de < 0) begin
               first_de = i;
               h_at_de  = int'(hpos_a);
               v_at_de  = int'(vpos_a);
            end
         end
      end
      check("a_first_hsync_idx", first_hs, 110);
      check("a_hsync_cycles", hs_cnt, 31 * 40);
      check("a_line_period", second_ls, 1650);
      check("a_line_starts", ls_cnt, 31);
      check("a_first_vsync_idx", first_vs, 5 * 1650);
      check("a_vsync_cycles", vs_cnt, 5 * 1650);
      check("a_vblank_cycles", vb_cnt, 30 * 1650);
      check("a_fsync_count", fs_cnt, 1);
      check("a_de_cycles", de_cnt, 1280);
      check("a_first_de_idx", first_de, 30 * 1650 + 370);
      check("a_first_de_hpos", h_at_de, 0);
      check("a_first_de_vpos", v_at_de, 0);
      check("a_fc_hold", int'(fc_a), 1);
      $display("a: hs_first=%0d hs=%0d vs=%0d vb=%0d de=%0d", first_hs, hs_cnt, vs_cnt, vb_cnt, de_cnt);

      for (int i = 0; i < 20000 && !wrap_done; i++) @(posedge clk);
      check("c_wrap_done", int'(wrap_done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates the raster timing that every renderer layer (star field, sprites, bullets, HUD) consumes.
- Produces signed hpos/vpos, a one-cycle fsync at frame start, hsync/vsync, data-enable, line-start and vblank strobes, and a frame counter.
- Active pixels sit at hpos/vpos >= 0; the blanking intervals precede the active region on each line and in each frame, so blanking coordinates are negative.
- Sits in the top level between the pixel clock source and all layer modules.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_POL, 1, hsync asserted level
- V_POL, 1, vsync asserted level

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel clock enable; advance one pixel per cycle when high
- hpos  out  12 signed  horizontal position, -H_BLANK .. H_ACTIVE-1
- vpos  out  12 signed  vertical position, -V_BLANK .. V_ACTIVE-1
- hsync  out  1  horizontal sync at H_POL level
- vsync  out  1  vertical sync at V_POL level
- de  out  1  high when hpos >= 0 and vpos >= 0
- fsync  out  1  one-cycle pulse at the first pixel of a frame
- line_start  out  1  one-cycle pulse at the first pixel of each line
- vblank  out  1  high when vpos < 0
- frame_count  out  16  frames started since reset; wraps

Behaviour:
- Derived sizes: H_BLANK = H_FP+H_SYNC+H_BP; V_BLANK = V_FP+V_SYNC+V_BP. Defaults give 1650x750 totals.
- All outputs are registered. Every output describes the pixel at the current hpos/vpos in the same cycle, with no skew between outputs.
- Reset (rst=1, takes priority over ce):
  - hpos=H_ACTIVE-1, vpos=V_ACTIVE-1, i.e. parked on the last pixel.
  - de=0, fsync=0, line_start=0, vblank=0, frame_count=0.
  - hsync=!H_POL, vsync=!V_POL.
- Advance rule, on each edge with rst=0 and ce=1:
  - If hpos == H_ACTIVE-1: hpos <= -H_BLANK and vpos advances, otherwise hpos <= hpos+1.
  - vpos advances as: if vpos == V_ACTIVE-1 then vpos <= -V_BLANK, else vpos <= vpos+1.
- Horizontal order within a line: front porch, sync, back porch, active.
  - hsync=H_POL for hpos in [-H_BLANK+H_FP, -H_BLANK+H_FP+H_SYNC-1].
- Vertical order within a frame: same order.
  - vsync=V_POL for vpos in [-V_BLANK+V_FP, -V_BLANK+V_FP+V_SYNC-1], for the entire line including horizontal blanking.
- Strobes:
  - line_start=1 exactly when hpos == -H_BLANK.
  - fsync=1 exactly when hpos == -H_BLANK and vpos == -V_BLANK.
  - fsync and line_start are never high during reset or on a cycle where ce was 0 on the preceding edge. Each pulse lasts exactly one cycle even if ce stays low afterward.
- frame_count increments by 1 on the same edge that raises fsync. It wraps 0xFFFF -> 0x0000.
- First edge after reset release with ce=1:
  - outputs go to hpos=-H_BLANK, vpos=-V_BLANK, fsync=1, line_start=1, vblank=1, frame_count=1.
  - frame 1 therefore starts immediately; no partial frame is produced.
- ce=0 edge: hpos, vpos, sync, de, vblank and frame_count hold; fsync and line_start go to 0.
- Reset mid-frame: returns to the parked state on the next edge, regardless of position.
- Width rule: all compares use 12-bit signed arithmetic. Designs must keep H_ACTIVE+H_BLANK <= 2047 and V_ACTIVE+V_BLANK <= 2047; violating this is a configuration error, flagged by a static assertion.

Test Plan:
- Defaults, ce=1, release reset:
  - first cycle shows hpos=-370, vpos=-30, fsync=1, frame_count=1.
  - fsync recurs every 1,237,500 cycles; frame_count=3 after 2 further periods.
- Defaults, one line:
  - hsync high for exactly 40 cycles starting 110 cycles after line_start.
  - de high for exactly 1280 cycles, starting when hpos=0.
  - line period is 1650 cycles.
- Defaults, one frame:
  - vsync high for exactly 5x1650 cycles starting 5 lines after fsync.
  - vblank high for 30 lines.
  - de pulses on 720 lines only.
- Small params (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1), H_POL=V_POL=0:
  - hpos sequence -3,-2,-1,0,1,2,3,-3.
  - hsync low only at hpos=-2.
  - vsync low only on vpos=-2.
- Toggle ce 1,0,0,1 across a line boundary:
  - line_start high for exactly one cycle.
  - counters hold during the ce=0 cycles.
  - no duplicate strobe when ce returns to 1.
- Assert rst for 1 cycle at hpos=500, vpos=300:
  - outputs match the parked reset values.
  - next ce edge produces fsync=1, frame_count=1.
- Preload a frame-count wrap via fast params:
  - after 65536 frames, frame_count reads 0x0000 on that fsync.
